// File: rtl/program_loader.sv
// program_loader: writes a framed HDR/LEN/START/words stream into one of three 512x9 program slots, then pulses init
//   in:  clk, reset (sync, active-high), in_data/in_valid (stream word + valid)
//   out: in_ready, wr_en/wr_prog/wr_addr/wr_data (slot write port, registered),
//        init/start_address (launch), slot_valid, err, busy
//   `CHECKSUM_EN: a trailing XOR word follows the last instruction; a mismatch cancels the launch
module program_loader #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [1:0]        wr_prog,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              init,
  output logic [ADDR_W-1:0] start_address,
  output logic [2:0]        slot_valid,
  output logic              err,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, LEN, START, LOAD, CHK, LAUNCH} state_t;
  state_t r_state, w_next;
  logic [1:0] r_slot;
  logic [ADDR_W-1:0] r_len, r_cnt, r_start;
  logic w_acc, w_last, w_err;
  logic [1:0] w_hdr;
  logic [2:0] w_clr_mask, w_set_mask;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] r_xor;
`endif
  assign in_ready = r_state != LAUNCH;
  assign busy = r_state != IDLE;
  assign w_acc = in_valid && in_ready;
  assign w_last = r_cnt == r_len;
  assign w_hdr = in_data[DATA_W-1 -: 2];
  // slot 00 minus one wraps to a shift of 3, giving an all-zero mask
  assign w_clr_mask = 3'b001 << (w_hdr - 2'd1);
  assign w_set_mask = 3'b001 << (r_slot - 2'd1);
  always_comb begin
    w_next = r_state;
    w_err = 1'b0;
    if (w_acc)
      case (r_state)
        IDLE: begin
          w_next = w_hdr != 2'b00 ? LEN : IDLE;
          w_err = w_hdr == 2'b00;
        end
        LEN: w_next = START;
        START: w_next = LOAD;
`ifdef CHECKSUM_EN
        LOAD: w_next = w_last ? CHK : LOAD;
        CHK: begin
          w_next = in_data == r_xor ? LAUNCH : IDLE;
          w_err = in_data != r_xor;
        end
`else
        LOAD: w_next = w_last ? LAUNCH : LOAD;
`endif
        default: w_next = r_state;
      endcase
    else if (r_state == LAUNCH)
      w_next = IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_slot <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_start <= '0;
      wr_en <= 1'b0;
      wr_prog <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      init <= 1'b0;
      start_address <= '0;
      slot_valid <= '0;
      err <= 1'b0;
`ifdef CHECKSUM_EN
      r_xor <= '0;
`endif
    end else begin
      r_state <= w_next;
      wr_en <= w_acc && r_state == LOAD;
      init <= r_state == LAUNCH;
      err <= w_err;
      if (w_acc && r_state == IDLE) begin
        r_slot <= w_hdr;
        slot_valid <= slot_valid & ~w_clr_mask;
      end
      if (r_state == LAUNCH) begin
        start_address <= r_start;
        slot_valid <= slot_valid | w_set_mask;
      end
      if (w_acc && r_state == LEN)
        r_len <= ADDR_W'(in_data);
      if (w_acc && r_state == START) begin
        r_start <= ADDR_W'(in_data);
        r_cnt <= '0;
`ifdef CHECKSUM_EN
        r_xor <= '0;
`endif
      end
      if (w_acc && r_state == LOAD) begin
        wr_prog <= r_slot;
        wr_addr <= r_cnt;
        wr_data <= in_data;
        r_cnt <= r_cnt + 1'b1;
`ifdef CHECKSUM_EN
        r_xor <= r_xor ^ in_data;
`endif
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader (writes and launches checked against queued expectations)
module tb_program_loader;
  logic clk = 0, reset = 1, in_valid = 0, in_ready;
  logic [8:0] in_data = 0;
  logic wr_en, init, err, busy;
  logic [1:0] wr_prog;
  logic [8:0] wr_addr, wr_data, start_address;
  logic [2:0] slot_valid;
  int total = 0, bad = 0, cyc = 0, n_err = 0, exp_err = 0;
  logic [35:0] exp_wr[$];
  logic [24:0] exp_init[$];
  logic [8:0] words[$];
  program_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_prog(wr_prog), .wr_addr(wr_addr), .wr_data(wr_data),
    .init(init), .start_address(start_address), .slot_valid(slot_valid), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_wr.size() == 0) check("wr_unexp", 1, 0);
      else check("wr", {cyc[15:0], wr_prog, wr_addr, wr_data}, exp_wr.pop_front());
    end
    if (init) begin
      if (exp_init.size() == 0) check("init_unexp", 1, 0);
      else check("init", {cyc[15:0], start_address}, exp_init.pop_front());
    end
    if (err) n_err++;
  end
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [8:0] d);
    bit ok = 0;
    in_data = d;
    in_valid = 1;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask
  task automatic frame(input logic [1:0] slot, input logic [8:0] st, input bit gap, input bit good);
    logic [8:0] x = 0;
    int n = words.size();
    send({slot, 7'h55});
    if (gap) idle(1);
    send(9'(n - 1));
    if (gap) idle(1);
    send(st);
    if (gap) idle(1);
    for (int i = 0; i < n; i++) begin
      send(words[i]);
      x ^= words[i];
      exp_wr.push_back({cyc[15:0], slot, 9'(i), words[i]});
      if (gap && i < n - 1) idle(1);
    end
`ifdef CHECKSUM_EN
    send(good ? x : x ^ 9'h003);
`endif
    in_valid = 0;
    if (good) begin
      exp_init.push_back({cyc[15:0] + 16'd1, st});
      check("launch_ready", {in_ready, busy}, 2'b01);
      idle(1);
      check("post_launch", {in_ready, busy}, 2'b10);
    end else
      exp_err++;
    idle(2);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_out", {wr_en, init, err, busy, wr_prog, wr_addr, wr_data, start_address, slot_valid, in_ready}, 37'd1);
    idle(20);
    check("idle_err", n_err, 0);
    words = '{9'h0A1, 9'h0B2, 9'h0C3};
    frame(2'b01, 9'd1, 0, 1);
    check("slot_after_1", slot_valid, 3'b001);
    frame(2'b10, 9'd1, 1, 1);
    check("slot_after_2", slot_valid, 3'b011);
    send(9'h07F);
    in_valid = 0;
    exp_err++;
    check("bad_hdr_busy", busy, 0);
    words = '{9'h1FF, 9'h000, 9'h155};
    frame(2'b01, 9'h1F0, 0, 1);
    check("bad_hdr_err", n_err, exp_err);
    check("slot_after_3", slot_valid, 3'b011);
    words.delete();
    for (int i = 0; i < 512; i++) words.push_back(9'(i * 37 + 5));
    frame(2'b11, 9'h100, 0, 1);
    check("slot_after_full", slot_valid, 3'b111);
    send(9'h180);
    check("reload_clear", slot_valid, 3'b011);
    send(9'd511);
    send(9'd0);
    for (int i = 0; i < 5; i++) begin
      send(9'(i + 9'h40));
      exp_wr.push_back({cyc[15:0], 2'b11, 9'(i), 9'(i + 9'h40)});
    end
    in_data = 9'h1AA;
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    in_valid = 0;
    check("mid_reset", {slot_valid, busy, in_ready}, 5'b00001);
    idle(10);
`ifdef CHECKSUM_EN
    words = '{9'h001, 9'h002};
    frame(2'b01, 9'd5, 0, 1);
    check("chk_good_slot", slot_valid, 3'b001);
    frame(2'b10, 9'd5, 0, 0);
    check("chk_bad_slot", slot_valid, 3'b001);
`endif
    check("err_count", n_err, exp_err);
    check("wr_left", exp_wr.size(), 0);
    check("init_left", exp_init.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
